// File: rtl/resetn_gen_if.sv
// Handshake bundle between the reset initiator and the per-domain reset synchronizers.
// master = reset initiator side, slave = downstream/environment side.
interface resetn_gen_if #(
    parameter int N_ACK = 2
);
    logic             soft_rst_req;
    logic [N_ACK-1:0] ack_rstn;
    logic             rstn_out;
    logic             busy;
    logic             done;
    logic             timeout;

    modport master (
        input  soft_rst_req,
        input  ack_rstn,
        output rstn_out,
        output busy,
        output done,
        output timeout
    );

    modport slave (
        output soft_rst_req,
        output ack_rstn,
        input  rstn_out,
        input  busy,
        input  done,
        input  timeout
    );
endinterface

// File: rtl/resetn_gen.sv
// Reset initiator: holds rstn_out low, waits for every domain to enter and then leave reset.
// Define RESETN_GEN_TIMEOUT_EN to bound each acknowledge wait and flag expiry on timeout.
module resetn_gen #(
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int N_ACK          = 2
) (
    input  logic          clk,
    input  logic          rstn_async,
    resetn_gen_if.master  bus
);
    localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT    = 2'd0,
        ST_WAIT_LOW  = 2'd1,
        ST_WAIT_HIGH = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_rstn_out;
    logic             r_busy;
    logic             r_done;

    logic [N_ACK-1:0] w_ack_sync;
    logic             w_acks_low;
    logic             w_acks_high;
    logic             w_wait_expired;

    // Each acknowledge is asynchronous to clk; only the second flop is ever looked at.
    genvar gi;
    generate
        for (gi = 0; gi < N_ACK; gi++) begin : g_ack_sync
            logic r_meta;
            logic r_sync;
            always_ff @(posedge clk or negedge rstn_async) begin
                if (!rstn_async) begin
                    r_meta <= 1'b0;
                    r_sync <= 1'b0;
                end else begin
                    r_meta <= bus.ack_rstn[gi];
                    r_sync <= r_meta;
                end
            end
            assign w_ack_sync[gi] = r_sync;
        end
    endgenerate

    assign w_acks_low  = ~|w_ack_sync;
    assign w_acks_high = &w_ack_sync;

`ifdef RESETN_GEN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout;
    logic             w_in_wait;
    logic             w_exit_met;

    assign w_in_wait      = (r_state == ST_WAIT_LOW) || (r_state == ST_WAIT_HIGH);
    assign w_exit_met     = (r_state == ST_WAIT_LOW) ? w_acks_low : w_acks_high;
    assign w_wait_expired = w_in_wait && (r_wait_cnt == WAIT_LAST);

    // Counter restarts on every state change, so it never passes its terminal value.
    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (bus.soft_rst_req) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (!w_in_wait || w_exit_met || w_wait_expired) begin
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_wait_expired && !w_exit_met) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign w_wait_expired = 1'b0;
    assign bus.timeout    = 1'b0;
`endif

    // Outputs are loaded together with the next state so rstn_out never glitches.
    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) begin
            r_state    <= ST_ASSERT;
            r_hold_cnt <= '0;
            r_rstn_out <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.soft_rst_req) begin
                r_state    <= ST_ASSERT;
                r_hold_cnt <= '0;
                r_rstn_out <= 1'b0;
                r_busy     <= 1'b1;
            end else begin
                case (r_state)
                    ST_ASSERT: begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_state <= ST_WAIT_LOW;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    ST_WAIT_LOW: begin
                        if (w_acks_low || w_wait_expired) begin
                            r_state    <= ST_WAIT_HIGH;
                            r_rstn_out <= 1'b1;
                        end
                    end
                    ST_WAIT_HIGH: begin
                        if (w_acks_high || w_wait_expired) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        r_state <= ST_RUN;
                    end
                endcase
            end
        end
    end

    assign bus.rstn_out = r_rstn_out;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
